// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader (see program_loader).
// The optional trailing-checksum feature is controlled by LOADER_CHECKSUM_EN.
package loader_pkg;

   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } loaderState_t;

   // Running XOR over the image data bytes; the header is never folded in.
   function automatic logic [7:0] csumUpdate(input logic [7:0] csum, input logic [7:0] dataByte);
      return csum ^ dataByte;
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects big-endian stream bytes into 32-bit words for the program loader.
// wordReady flags the handshake that delivers the last byte of a word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shiftEn,
   input  logic [7:0]  byteIn,
   output logic [31:0] word,
   output logic        wordReady
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] byteIdx_r;
   logic [31:0]      shift_r;

   // Byte index and shift register; first byte of a word ends up in bits 31:24.
   always_ff @(posedge clk) begin
      if (rst) begin
         byteIdx_r <= IDX_W'(0);
         shift_r   <= 32'h0000_0000;
      end else if (clear) begin
         byteIdx_r <= IDX_W'(0);
      end else if (shiftEn) begin
         byteIdx_r <= byteIdx_r + IDX_W'(1);
         shift_r   <= {shift_r[23:0], byteIn};
      end
   end

   assign word      = shift_r;
   assign wordReady = shiftEn && (byteIdx_r == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: framed byte stream -> instruction memory, CPU held in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image data.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam int CNT_W = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
   localparam loaderState_t FRAME_END = ST_CHECK;
`else
   localparam loaderState_t FRAME_END = ST_DONE;
`endif

   loaderState_t      state_r;
   loaderState_t      nextState_s;
   logic              handshake_s;
   logic              startLoad_s;
   logic              wordReady_s;
   logic [LEN_W-1:0]  lenN_s;
   logic [LEN_W-1:0]  countPlusOne_s;
   logic [7:0]        lenHi_r;
   logic [LEN_W-1:0]  target_r;
   logic [CNT_W-1:0]  wordCount_r;
   logic [ADDR_W-1:0] imemAddr_r;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_r;
`endif

   logic rxReady_r, imemWe_r, cpuRst_r, busy_r, done_r, error_r;
   logic rxReadyNext_s, imemWeNext_s, cpuRstNext_s, busyNext_s, doneNext_s, errorNext_s;

   assign handshake_s    = rx_valid && rxReady_r;
   assign startLoad_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
   assign lenN_s         = {lenHi_r, rx_data};
   assign countPlusOne_s = LEN_W'(wordCount_r) + LEN_W'(1);

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (startLoad_s),
      .shiftEn   (handshake_s && (state_r == ST_DATA)),
      .byteIn    (rx_data),
      .word      (imem_wdata),
      .wordReady (wordReady_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state logic.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) nextState_s = ST_LEN_HI;
            else       nextState_s = state_r;
         end
         ST_LEN_HI: begin
            if (handshake_s) nextState_s = ST_LEN_LO;
            else             nextState_s = state_r;
         end
         ST_LEN_LO: begin
            if (!handshake_s)                       nextState_s = state_r;
            else if (lenN_s > LEN_W'(MAX_WORDS))    nextState_s = ST_ERR;
            else if (lenN_s == LEN_W'(0))           nextState_s = FRAME_END;
            else                                    nextState_s = ST_DATA;
         end
         ST_DATA: begin
            if (wordReady_s) nextState_s = ST_WRITE;
            else             nextState_s = state_r;
         end
         ST_WRITE: begin
            if (countPlusOne_s == target_r) nextState_s = FRAME_END;
            else                            nextState_s = ST_DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (!handshake_s)          nextState_s = state_r;
            else if (rx_data == csum_r) nextState_s = ST_DONE;
            else                        nextState_s = ST_ERR;
         end
`endif
         default: nextState_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output leaves a flop.
   always_comb begin
      rxReadyNext_s = 1'b0;
      imemWeNext_s  = 1'b0;
      cpuRstNext_s  = 1'b1;
      busyNext_s    = 1'b0;
      doneNext_s    = 1'b0;
      errorNext_s   = 1'b0;
      case (nextState_s)
         ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: begin
            rxReadyNext_s = 1'b1;
            busyNext_s    = 1'b1;
         end
         ST_WRITE: begin
            imemWeNext_s = 1'b1;
            busyNext_s   = 1'b1;
         end
         ST_DONE: begin
            cpuRstNext_s = 1'b0;
            doneNext_s   = 1'b1;
         end
         ST_ERR: begin
            errorNext_s = 1'b1;
         end
         default: begin
            rxReadyNext_s = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxReady_r <= 1'b0;
         imemWe_r  <= 1'b0;
         cpuRst_r  <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         error_r   <= 1'b0;
      end else begin
         rxReady_r <= rxReadyNext_s;
         imemWe_r  <= imemWeNext_s;
         cpuRst_r  <= cpuRstNext_s;
         busy_r    <= busyNext_s;
         done_r    <= doneNext_s;
         error_r   <= errorNext_s;
      end
   end

   // Header capture, address/count advance and checksum accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         lenHi_r     <= 8'h00;
         target_r    <= LEN_W'(0);
         wordCount_r <= CNT_W'(0);
         imemAddr_r  <= ADDR_W'(0);
`ifdef LOADER_CHECKSUM_EN
         csum_r      <= 8'h00;
`endif
      end else if (startLoad_s) begin
         wordCount_r <= CNT_W'(0);
         imemAddr_r  <= ADDR_W'(0);
`ifdef LOADER_CHECKSUM_EN
         csum_r      <= 8'h00;
`endif
      end else begin
         if (handshake_s && (state_r == ST_LEN_HI)) lenHi_r <= rx_data;
         if (handshake_s && (state_r == ST_LEN_LO)) target_r <= lenN_s;
         if (state_r == ST_WRITE) begin
            wordCount_r <= wordCount_r + CNT_W'(1);
            imemAddr_r  <= imemAddr_r + ADDR_W'(1);
         end
`ifdef LOADER_CHECKSUM_EN
         if (handshake_s && (state_r == ST_DATA)) csum_r <= csumUpdate(csum_r, rx_data);
`endif
      end
   end

   assign rx_ready   = rxReady_r;
   assign imem_we    = imemWe_r;
   assign imem_addr  = imemAddr_r;
   assign cpu_rst    = cpuRst_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;
   assign word_count = wordCount_r;

endmodule
